sign_extend_unit: RTL and testbench
===================================

Name: sign_extend_unit

Overview:
- Immediate-extension unit for the single-cycle MIPS datapath.
- Widens the 16-bit instruction immediate to 32 bits for the ALU B-input mux and the branch-target adder.
- Primary result `y` is purely combinational: default mode gives classic 16→32 sign extension.
- A registered copy with a valid flag also feeds the pipelined/trace path, clocked by the single system clock.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; must be ≥ IN_W+2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- a  input  IN_W  immediate field (instr[15:0]).
- mode  input  3  extension mode select; tie to 0 for plain sign extension.
- in_valid  input  1  qualifies a/mode for the registered path.
- y  output  OUT_W  combinational extended result.
- neg  output  1  combinational, equals y[OUT_W-1].
- y_q  output  OUT_W  registered y.
- out_valid  output  1  registered in_valid.

Behaviour:
- `y` is a function of `a` and `mode` only: zero-latency, no dependence on clk or reset_n.
- mode 000: sign-extend. y = {16{a[15]}, a}.
- mode 001: zero-extend. y = {16'h0000, a}.
- mode 010: load-upper. y = {a, 16'h0000}.
- mode 011: branch offset. y = sign-extended a shifted left 2.
  - Bits [1:0] = 0.
  - Bits [17:2] = a.
  - Bits [31:18] = a[15].
- mode 100: sign-extend low byte. y = {24{a[7]}, a[7:0]}; a[15:8] ignored.
- mode 101: zero-extend low byte. y = {24'h0, a[7:0]}.
- modes 110, 111: reserved; behave exactly as mode 000, with no error flag.
- neg = y[31] in every mode.
- Registered path:
  - On each rising clk edge with reset_n high: y_q <= y if in_valid=1, else y_q holds; out_valid <= in_valid.
  - Latency is one cycle.
- Reset:
  - reset_n low asynchronously forces y_q = 0 and out_valid = 0 immediately, independent of clk.
  - The combinational `y` and `neg` are unaffected by reset.
  - Deassertion takes effect at the first rising edge with reset_n high.
  - Reset asserted mid-stream discards the in-flight value; no capture occurs while reset_n is low.
- Boundaries:
  - a = 16'h0000 gives y = 0 in all modes.
  - a = 16'h8000 in mode 000 gives FFFF8000.
  - a = 16'h7FFF in mode 000 gives 00007FFF.
- No X-propagation from unused input bits in byte modes; any X on a[15:8] must not reach y.

Test Plan:
- mode=0, a=16'h1234, wait 10 ns → y=32'h00001234, neg=0 (no clock needed).
- mode=0, a=16'hFEDC, wait 10 ns → y=32'hFFFFFEDC, neg=1; a=16'h8000 → FFFF8000; a=16'h7FFF → 00007FFF.
- mode=1 a=FEDC → 0000FEDC; mode=2 a=1234 → 12340000; mode=3 a=FFFF → FFFFFFFC; mode=3 a=0001 → 00000004.
- mode=4 a=12F0 → FFFFFFF0; mode=5 a=12F0 → 000000F0; mode=6 and 7 a=FEDC → FFFFFEDC.
- Registered path, mode=0:
  - in_valid=1, a=FEDC, one clk edge → y_q=FFFFFEDC, out_valid=1.
  - in_valid=0, a=1234, next edge → y_q holds FFFFFEDC, out_valid=0.
- Reset: with y_q non-zero, drop reset_n between edges → y_q=0 and out_valid=0 immediately; y still tracks a; no capture until reset_n high and next edge.

Source files
------------

// File: rtl/sign_extend_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sign_extend_unit
//  Description : Immediate-extension unit for the single-cycle MIPS datapath.
//                Combinational extended result plus a registered copy with a
//                valid flag for the pipelined/trace path.
//  Revision    : 1.0 - initial release
// ============================================================================
module sign_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  a,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] y,
    output logic             neg,
    output logic [OUT_W-1:0] y_q,
    output logic             out_valid
);

    localparam logic [2:0] c_MODE_SEXT  = 3'b000;
    localparam logic [2:0] c_MODE_ZEXT  = 3'b001;
    localparam logic [2:0] c_MODE_LUI   = 3'b010;
    localparam logic [2:0] c_MODE_BR    = 3'b011;
    localparam logic [2:0] c_MODE_SBYTE = 3'b100;
    localparam logic [2:0] c_MODE_ZBYTE = 3'b101;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_lui;
    logic [OUT_W-1:0] w_br;
    logic [OUT_W-1:0] w_sbyte;
    logic [OUT_W-1:0] w_zbyte;
    logic [OUT_W-1:0] w_y;

    logic [OUT_W-1:0] r_y_q;
    logic             r_out_valid;

    assign w_sext  = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
    assign w_zext  = {{(OUT_W-IN_W){1'b0}}, a};
    assign w_lui   = {a, {(OUT_W-IN_W){1'b0}}};
    assign w_br    = w_sext << 2;
    // Byte modes only ever look at a[7:0], so the upper immediate bits can
    // never leak (even as X) into the result.
    assign w_sbyte = {{(OUT_W-8){a[7]}}, a[7:0]};
    assign w_zbyte = {{(OUT_W-8){1'b0}}, a[7:0]};

    // Reserved encodings fall through to plain sign extension.
    always_comb begin
        w_y = w_sext;
        case (mode)
            c_MODE_SEXT:  w_y = w_sext;
            c_MODE_ZEXT:  w_y = w_zext;
            c_MODE_LUI:   w_y = w_lui;
            c_MODE_BR:    w_y = w_br;
            c_MODE_SBYTE: w_y = w_sbyte;
            c_MODE_ZBYTE: w_y = w_zbyte;
            default:      w_y = w_sext;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y_q <= w_y;
            end
        end
    end

    assign y         = w_y;
    assign neg       = w_y[OUT_W-1];
    assign y_q       = r_y_q;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sign_extend_unit.sv
`default_nettype none
// Testbench for sign_extend_unit: directed literal checks plus randomized
// stimulus against an arithmetic reference model.
module tb_sign_extend_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] a;
    logic [2:0]  mode;
    logic        in_valid;
    logic [31:0] y;
    logic        neg;
    logic [31:0] y_q;
    logic        out_valid;

    int n_cmp;
    int n_bad;
    bit cmp_en;

    logic [31:0] exp_yq;
    logic        exp_ov;

    sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .mode      (mode),
        .in_valid  (in_valid),
        .y         (y),
        .neg       (neg),
        .y_q       (y_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] v, input logic [2:0] m);
        int s16;
        int s8;
        int u16;
        s16 = int'($signed(v));
        s8  = int'($signed(v[7:0]));
        u16 = int'(v);
        case (m)
            3'd1:    return 32'(u16);
            3'd2:    return 32'(u16 * 65536);
            3'd3:    return 32'(s16 * 4);
            3'd4:    return 32'(s8);
            3'd5:    return 32'(u16 % 256);
            default: return 32'(s16);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (a=%h mode=%0d t=%0t)", name, act, exp, a, mode, $time);
        end
    endtask

    // Reference for the registered path.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_yq = 32'h0;
            exp_ov = 1'b0;
        end else begin
            if (in_valid) exp_yq = model(a, mode);
            exp_ov = in_valid;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("y_rand",   y, model(a, mode));
            chk("neg_rand", {31'b0, neg}, {31'b0, model(a, mode) >> 31});
            chk("y_q_rand", y_q, exp_yq);
            chk("ov_rand",  {31'b0, out_valid}, {31'b0, exp_ov});
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [2:0]  m;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[14];

    initial begin
        n_cmp = 0; n_bad = 0; cmp_en = 0;
        reset_n = 1'b0; in_valid = 1'b0; a = 16'h0; mode = 3'd0;

        vecs[0]  = '{16'h1234, 3'd0, 32'h00001234};
        vecs[1]  = '{16'hFEDC, 3'd0, 32'hFFFFFEDC};
        vecs[2]  = '{16'h8000, 3'd0, 32'hFFFF8000};
        vecs[3]  = '{16'h7FFF, 3'd0, 32'h00007FFF};
        vecs[4]  = '{16'hFEDC, 3'd1, 32'h0000FEDC};
        vecs[5]  = '{16'h1234, 3'd2, 32'h12340000};
        vecs[6]  = '{16'hFFFF, 3'd3, 32'hFFFFFFFC};
        vecs[7]  = '{16'h0001, 3'd3, 32'h00000004};
        vecs[8]  = '{16'h12F0, 3'd4, 32'hFFFFFFF0};
        vecs[9]  = '{16'h12F0, 3'd5, 32'h000000F0};
        vecs[10] = '{16'hFEDC, 3'd6, 32'hFFFFFEDC};
        vecs[11] = '{16'hFEDC, 3'd7, 32'hFFFFFEDC};
        vecs[12] = '{16'h8001, 3'd3, 32'hFFFE0004};
        vecs[13] = '{16'h0080, 3'd4, 32'hFFFFFF80};

        // Combinational checks while reset is held: y must ignore reset.
        foreach (vecs[i]) begin
            a = vecs[i].a; mode = vecs[i].m;
            #10;
            chk("y_lit",   y, vecs[i].y);
            chk("neg_lit", {31'b0, neg}, {31'b0, vecs[i].y[31]});
            chk("model_lit", model(vecs[i].a, vecs[i].m), vecs[i].y);
        end
        a = 16'h0000;
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            #2;
            chk("y_zero", y, 32'h0);
        end
        // Upper byte undriven in a byte mode must not disturb y.
        a = {8'hxx, 8'h85}; mode = 3'd4; #2;
        chk("y_xbyte_s", y, 32'hFFFFFF85);
        mode = 3'd5; #2;
        chk("y_xbyte_z", y, 32'h00000085);

        chk("y_q_rst", y_q, 32'h0);
        chk("ov_rst",  {31'b0, out_valid}, 32'h0);

        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        mode = 3'd0; a = 16'hFEDC; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("y_q_cap", y_q, 32'hFFFFFEDC);
        chk("ov_cap",  {31'b0, out_valid}, 32'h1);
        a = 16'h1234; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("y_q_hold", y_q, 32'hFFFFFEDC);
        chk("ov_hold",  {31'b0, out_valid}, 32'h0);

        // Asynchronous reset mid-cycle with a value in flight.
        in_valid = 1'b1; a = 16'h1111;
        @(negedge clk); #2;
        reset_n = 1'b0; #1;
        chk("y_q_async", y_q, 32'h0);
        chk("ov_async",  {31'b0, out_valid}, 32'h0);
        chk("y_in_rst",  y, 32'h00001111);
        @(posedge clk); #1;
        chk("y_q_in_rst", y_q, 32'h0);
        chk("ov_in_rst",  {31'b0, out_valid}, 32'h0);
        @(negedge clk); reset_n = 1'b1; #1;
        chk("y_q_rel", y_q, 32'h0);
        @(posedge clk); #1;
        chk("y_q_after", y_q, 32'h00001111);
        chk("ov_after",  {31'b0, out_valid}, 32'h1);

        cmp_en = 1;
        for (int c = 0; c < 3000; c++) begin
            a        = 16'($urandom);
            mode     = 3'($urandom_range(0, 7));
            in_valid = 1'($urandom);
            reset_n  = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        cmp_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
